// File: rtl/bottle_fill_ctrl.sv
// Per-bottle filling-station sequencer: conveyor -> fill -> seal -> eject.
// Debounces the raw presence sensor; all actuator and status outputs are flop outputs.
module bottle_fill_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FILL_TIMEOUT    = 50,
    parameter int unsigned SEAL_CYCLES     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fault_clr,
    input  logic       bottle_sensor,
    input  logic       level_full,
    output logic       motor_on,
    output logic       valve_open,
    output logic       sealer_on,
    output logic       count_enable,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned CODE_W  = 2;

    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
    localparam logic [TIMER_W-1:0] DB_LAST    = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SEAL_LAST  = TIMER_W'(SEAL_CYCLES - 1);

    localparam logic [CODE_W-1:0] CODE_NONE    = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_TIMEOUT = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_LOST    = CODE_W'(2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        FILL  = 3'd2,
        SEAL  = 3'd3,
        EJECT = 3'd4,
        FAULT = 3'd5
    } state_t;

    // Sensor synchronizer and stability filter
    logic               sync1;
    logic               sync2;
    logic               sens_db;
    logic [TIMER_W-1:0] db_cnt;
    logic               db_toggle;
    logic               db_rise;
    logic               db_fall;

    always_comb begin
        db_toggle = (sync2 != sens_db) && (db_cnt == DB_LAST);
        db_rise   = db_toggle && !sens_db;
        db_fall   = db_toggle && sens_db;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sens_db <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1 <= bottle_sensor;
            sync2 <= sync1;
            if (sync2 == sens_db) begin
                db_cnt <= '0;
            end else if (db_toggle) begin
                sens_db <= ~sens_db;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + TIMER_W'(1);
            end
        end
    end

    // Sequencer state and registered outputs
    state_t              state_r;
    state_t              state_nx;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timer_nx;
    logic [TIMER_W-1:0]  timer_inc;
    logic                stop_req;
    logic                stop_req_nx;
    logic [CODE_W-1:0]   code_nx;
    logic                count_nx;
    logic                motor_nx;
    logic                valve_nx;
    logic                sealer_nx;
    logic                busy_nx;
    logic                fault_nx;
    logic                busy_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            timer        <= '0;
            stop_req     <= 1'b0;
            fault_code   <= CODE_NONE;
            count_enable <= 1'b0;
            motor_on     <= 1'b0;
            valve_open   <= 1'b0;
            sealer_on    <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_r      <= state_nx;
            timer        <= timer_nx;
            stop_req     <= stop_req_nx;
            fault_code   <= code_nx;
            count_enable <= count_nx;
            motor_on     <= motor_nx;
            valve_open   <= valve_nx;
            sealer_on    <= sealer_nx;
            busy         <= busy_nx;
            fault        <= fault_nx;
        end
    end

    always_comb begin
        state_nx    = state_r;
        timer_nx    = timer;
        stop_req_nx = stop_req;
        code_nx     = fault_code;
        count_nx    = 1'b0;
        busy_now    = (state_r != IDLE) && (state_r != FAULT);
        timer_inc   = (timer == TIMER_MAX) ? timer : timer + TIMER_W'(1);

        if (busy_now && stop) begin
            stop_req_nx = 1'b1;
        end

        case (state_r)
            IDLE: begin
                stop_req_nx = 1'b0;
                timer_nx    = '0;
                if (start && !stop) begin
                    state_nx = MOVE;
                end
            end
            MOVE: begin
                if (db_rise) begin
                    state_nx = FILL;
                    timer_nx = '0;
                end else if (stop_req && !sens_db) begin
                    state_nx = IDLE;
                end
            end
            FILL: begin
                // Losing the bottle outranks both level_full and the timeout
                if (db_fall) begin
                    state_nx = FAULT;
                    code_nx  = CODE_LOST;
                end else if (level_full) begin
                    state_nx = SEAL;
                    timer_nx = '0;
                end else if (timer == FILL_LAST) begin
                    state_nx = FAULT;
                    code_nx  = CODE_TIMEOUT;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            SEAL: begin
                if (db_fall) begin
                    state_nx = FAULT;
                    code_nx  = CODE_LOST;
                end else if (timer == SEAL_LAST) begin
                    state_nx = EJECT;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            EJECT: begin
                if (db_fall) begin
                    count_nx = 1'b1;
                    state_nx = stop_req ? IDLE : MOVE;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nx = IDLE;
                    code_nx  = CODE_NONE;
                end
            end
            default: begin
                state_nx = IDLE;
                code_nx  = CODE_NONE;
            end
        endcase

        // Outputs are decoded from the next state so they land with the state flop
        motor_nx  = (state_nx == MOVE) || (state_nx == EJECT);
        valve_nx  = (state_nx == FILL);
        sealer_nx = (state_nx == SEAL);
        busy_nx   = (state_nx != IDLE) && (state_nx != FAULT);
        fault_nx  = (state_nx == FAULT);
    end

    assign state = state_r;

endmodule
